// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory image loader.
package imem_loader_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 12;
  localparam int unsigned MAX_WORDS      = 2 ** ADDR_WIDTH_DEF;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_e;

  // Word capacity of a memory with aw address bits.
  function automatic logic [31:0] max_words(input int unsigned aw);
    return 32'(1) << aw;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream image loader: length header, big-endian payload words, XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wEn,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [31:0] MAX_N = max_words(ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      addr_q, addr_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [BYTE_W-1:0]     chk_q, chk_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  xfer_c;

  assign xfer_c = in_valid & in_ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      chk_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_reset_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      in_ready_q  <= in_ready_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    chk_d      = chk_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_HI;
          addr_d  = '0;
          chk_d   = '0;
          bcnt_d  = '0;
        end
      end
      LEN_HI: begin
        if (xfer_c) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer_c) begin
          len_d   = {len_q[15:8], in_data};
          state_d = (len_d == '0 || 32'(len_d) > MAX_N) ? ERROR : DATA;
        end
      end
      DATA: begin
        if (xfer_c) begin
          word_d = (word_q << 8) | WORD_W'(in_data);
          chk_d  = chk_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + CNT_W'(1);
        state_d = (32'(addr_d) == 32'(len_q)) ? CHECK : DATA;
      end
      CHECK: begin
        if (xfer_c) state_d = (in_data == chk_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they switch on the same edge.
    in_ready_d  = state_d inside {LEN_HI, LEN_LO, DATA, CHECK};
    mem_wen_d   = (state_d == WRITE);
    cpu_reset_d = !(state_d inside {IDLE, DONE});
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
    if (mem_wen_d) begin
      mem_addr_d = addr_q[ADDR_WIDTH-1:0];
      mem_data_d = DATA_WIDTH'(word_d);
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_wEn    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_dataIn = mem_data_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, length limits, full-depth load, gaps, reset mid-load.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_wEn;
  logic [11:0] mem_addr;
  logic [31:0] mem_dataIn;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          wr_base = 0;
  logic        prev_wen = 1'b0;
  logic [31:0] exp_words[$];

  imem_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_wEn   (mem_wEn),
    .mem_addr  (mem_addr),
    .mem_dataIn(mem_dataIn),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write pulse is checked against the expected image at the current load index.
  always @(negedge clock) begin
    if (mem_wEn) begin
      check("wen_single", 64'(prev_wen), 64'd0);
      check("wr_addr", 64'(mem_addr), 64'(wr_cnt - wr_base));
      if ((wr_cnt - wr_base) < exp_words.size())
        check("wr_data", 64'(mem_dataIn), 64'(exp_words[wr_cnt - wr_base]));
      else
        check("wr_extra", 64'(mem_wEn), 64'd0);
      wr_cnt++;
    end
    prev_wen = mem_wEn;
  end

  function automatic logic [7:0] xor_words();
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    foreach (exp_words[i]) begin
      w = exp_words[i];
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n = 0;
    repeat ($urandom_range(gap_max, 0)) @(negedge clock);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("rdy_wait", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic run_stream(input logic [15:0] len, input logic [7:0] chk, input int stop_words,
                            input int gap_max, input bit mid_start);
    logic [31:0] w;
    int          n;
    wr_base = wr_cnt;
    pulse_start();
    check("start_cpu_rst", 64'(cpu_reset), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_error", 64'(error), 64'd0);
    check("start_ready", 64'(in_ready), 64'd1);
    send_byte(len[15:8], gap_max);
    send_byte(len[7:0], gap_max);
    for (int i = 0; i < exp_words.size(); i++) begin
      w = exp_words[i];
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap_max);
      if (mid_start && i == 0) pulse_start();
      if (stop_words != 0 && i + 1 == stop_words) begin
        n = 0;
        while ((wr_cnt - wr_base) < stop_words && n < 10) begin
          @(negedge clock);
          n++;
        end
        check("stop_wait", 64'(wr_cnt - wr_base), 64'(stop_words));
        return;
      end
    end
    send_byte(chk, gap_max);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_wen"}, 64'(mem_wEn), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_data"}, 64'(mem_dataIn), 64'd0);
    check({tag, "_cpu_rst"}, 64'(cpu_reset), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic len_err_case(input logic [15:0] len);
    wr_base = wr_cnt;
    pulse_start();
    check("lerr_clr", 64'(error), 64'd0);
    send_byte(len[15:8], 0);
    send_byte(len[7:0], 0);
    check("lerr_error", 64'(error), 64'd1);
    check("lerr_cpu_rst", 64'(cpu_reset), 64'd1);
    check("lerr_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clock);
    check("lerr_no_wr", 64'(wr_cnt - wr_base), 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("rst");

    // Bytes offered while idle must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clock);
    check("idle_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Good load: payload XOR 13^DE^AD^BE^EF = 0x31.
    exp_words = '{32'h0000_0013, 32'hDEAD_BEEF};
    run_stream(16'd2, 8'h31, 0, 0, 1'b0);
    check("ok_done", 64'(done), 64'd1);
    check("ok_error", 64'(error), 64'd0);
    check("ok_cpu_rst", 64'(cpu_reset), 64'd0);
    check("ok_writes", 64'(wr_cnt - wr_base), 64'd2);

    // Same image, wrong checksum: error held until the next start.
    run_stream(16'd2, 8'h00, 0, 0, 1'b0);
    check("bad_error", 64'(error), 64'd1);
    check("bad_done", 64'(done), 64'd0);
    check("bad_writes", 64'(wr_cnt - wr_base), 64'd2);
    repeat (5) @(negedge clock);
    check("bad_hold_err", 64'(error), 64'd1);
    check("bad_hold_rst", 64'(cpu_reset), 64'd1);

    len_err_case(16'h0000);
    len_err_case(16'h1001);

    // Full-depth load of incrementing words.
    exp_words.delete();
    for (int i = 0; i < 4096; i++) exp_words.push_back(32'(i));
    run_stream(16'h1000, xor_words(), 0, 0, 1'b0);
    check("full_done", 64'(done), 64'd1);
    check("full_writes", 64'(wr_cnt - wr_base), 64'd4096);
    check("full_addr_hold", 64'(mem_addr), 64'hFFF);
    check("full_data_hold", 64'(mem_dataIn), 64'h0000_0FFF);

    // Random gaps and an ignored mid-load start must write the same image.
    exp_words = '{32'h0000_0013, 32'hDEAD_BEEF};
    run_stream(16'd2, 8'h31, 0, 3, 1'b1);
    check("gap_done", 64'(done), 64'd1);
    check("gap_writes", 64'(wr_cnt - wr_base), 64'd2);

    // Reset after two of three words, then a clean reload.
    exp_words = '{32'hA0B0_C0D0, 32'h0102_0304, 32'hCAFE_F00D};
    run_stream(16'd3, xor_words(), 2, 0, 1'b0);
    #2 reset = 1'b1;
    #1 check_idle_outputs("mid_rst");
    @(negedge clock) reset = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_rst_writes", 64'(wr_cnt - wr_base), 64'd2);
    run_stream(16'd3, xor_words(), 0, 0, 1'b0);
    check("reload_done", 64'(done), 64'd1);
    check("reload_writes", 64'(wr_cnt - wr_base), 64'd3);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
